adc_sample_conditioner: RTL
===========================

# adc_sample_conditioner

Conditions the raw 10-bit ADC sample stream before it enters the dual-clock FIFO toward the FX3. Runs in the 40 MHz ADC clock domain, directly downstream of ADC sample capture and upstream of the FIFO write port. It discards settling samples after capture start and tags every sample with a rolling sequence number so the host can detect drops. It also flags ADC clipping and counts samples written while the FIFO is full.

## Interface

- DISCARD_COUNT, 16: number of samples discarded after each capture start (0 = none)
- CLIP_HOLD, 1024: cycles clipIndicator stays high after the last clipped sample
- clock  input  1  ADC sample clock (40 MHz PLL output)
- nReset  input  1  reset; one clock, reset is asynchronous and active-low
- runFlag  input  1  capture enable, level-sensitive
- adcDatabus  input  10  raw ADC sample, unsigned, sampled every clock
- fifoFull  input  1  FIFO full flag, already synchronised into this domain
- adcData  output  16  {seq[5:0], sample[9:0]} FIFO write data
- dataValid  output  1  FIFO write enable, aligned with adcData
- clipIndicator  output  1  stretched clip flag
- clipCount  output  16  saturating count of clipped valid samples
- overflowFlag  output  1  sticky: a valid sample was presented while fifoFull was high
- overflowCount  output  16  saturating count of such samples

## Operation

- FSM states: IDLE, DISCARD, RUN. Reset enters IDLE.
- IDLE: runFlag=1 → DISCARD, or → RUN if DISCARD_COUNT=0. Discard counter and seq are cleared, and overflowFlag is cleared, on this transition.
- DISCARD: the counter increments every cycle. At the cycle where it reaches DISCARD_COUNT-1 → RUN.
- RUN: stays while runFlag=1.
- Any state with runFlag=0 → IDLE on the next edge. Mid-discard or mid-run abort is allowed.
- Stage 1 captures adcDatabus unconditionally every cycle.
- Stage 2 registers adcData = {seq, stage1} and dataValid = (state==RUN). Seq increments after every valid word and wraps 63→0.
- Clip: a valid sample equal to 10'h000 or 10'h3FF.
  - clipCount increments, saturating at 16'hFFFF.
  - The hold counter reloads to CLIP_HOLD-1 and clipIndicator=1.
  - clipIndicator falls when the hold counter reaches 0 with no new clip.
- Overflow: dataValid=1 with fifoFull=1 increments overflowCount (saturating) and sets overflowFlag.
  - The word is still presented; the FIFO drops it.
  - seq still increments, so the host sees the gap.
- clipCount and overflowCount clear only on reset.

## Timing

- Reset values:
  - adcData=0, dataValid=0, clipIndicator=0, clipCount=0, overflowFlag=0, overflowCount=0, seq=0, state=IDLE.
- Latency is 2 cycles from adcDatabus to adcData.
- If runFlag is first sampled high at edge N:
  - DISCARD runs for edges N+1 to N+DISCARD_COUNT.
  - RUN begins at edge N+DISCARD_COUNT.
  - The first dataValid=1 is at edge N+DISCARD_COUNT+1.
  - With DISCARD_COUNT=0, the first dataValid=1 is at edge N+1.
- If runFlag is sampled low at edge M, dataValid=0 from edge M+1.
- Counters update one edge after the qualifying dataValid word.
- A clip and an overflow on the same word both count.
- Simultaneous clip and hold expiry: the reload wins.
- Asynchronous reset mid-run zeroes everything immediately. The next start reapplies the discard.

## Configuration

- TEST_PATTERN_EN defined:
  - Adds input port testMode (1 bit).
  - When testMode=1, the stage-1 source is a 10-bit ramp instead of adcDatabus.
  - The ramp resets to 0 on IDLE→DISCARD/RUN and increments every cycle, wrapping 1023→0.
  - Clip detection still applies to the ramp, so 0 and 1023 count as clips.
- TEST_PATTERN_EN undefined:
  - The testMode port is absent.
  - The ramp logic is not built.
  - The source is always adcDatabus.

## Structure

- The shared package dd_sample_pkg holds:
  - the state enum (IDLE/DISCARD/RUN)
  - SAMPLE_W=10, SEQ_W=6, WORD_W=16, CNT_W=16
  - CLIP_LO=10'h000, CLIP_HI=10'h3FF
- One sub-module, sat_counter: a 16-bit saturating counter with increment enable. It is instantiated twice, for clipCount and overflowCount.
- The hold counter and FSM stay inline.

## Test plan

- Reset, then runFlag=1 with DISCARD_COUNT=16 and adcDatabus=10'h155 → the first dataValid is 17 cycles after runFlag is sampled, with adcData=16'h0155, then 16'h0555, 16'h0955, and so on (seq 0,1,2).
- Run 70 valid samples → the seq field wraps 63→0 on the 65th word, and the sample field is intact.
- Drive 10'h3FF for one valid cycle, then 10'h200, with CLIP_HOLD=8 → clipCount=1; clipIndicator stays high for exactly 8 cycles after the clip, then drops.
- Hold fifoFull=1 for 5 valid cycles → overflowCount=5 and overflowFlag=1. A new runFlag rise clears overflowFlag but keeps overflowCount=5.
- Drop runFlag mid-DISCARD at count 7, then re-assert → the full 16-sample discard is reapplied and seq restarts at 0. Assert nReset low mid-RUN → all outputs are 0 asynchronously.
- Under TEST_PATTERN_EN with testMode=1 and DISCARD_COUNT=0 → the sample field equals the ramp (0,1,2,…). clipCount increments at ramp values 0 and 1023.

Source files
------------

// File: rtl/dd_sample_pkg.sv
// Shared types and constants for the ADC sample conditioning path.
package dd_sample_pkg;

    localparam int SAMPLE_W = 10;
    localparam int SEQ_W    = 6;
    localparam int WORD_W   = 16;
    localparam int CNT_W    = 16;

    localparam logic [SAMPLE_W-1:0] CLIP_LO = 10'h000;
    localparam logic [SAMPLE_W-1:0] CLIP_HI = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISCARD = 2'd1,
        RUN     = 2'd2
    } state_e;

    function automatic logic is_clip(input logic [SAMPLE_W-1:0] sample);
        return (sample == CLIP_LO) || (sample == CLIP_HI);
    endfunction

endpackage

// File: rtl/adc_sample_conditioner_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
module sat_counter
    import dd_sample_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only when enabled and not yet saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: settling discard, sequence tagging, clip and overflow monitoring.
// Optional ramp test source selected by testMode when TEST_PATTERN_EN is defined.
module adc_sample_conditioner
    import dd_sample_pkg::*;
#(
    parameter int DISCARD_COUNT = 16,
    parameter int CLIP_HOLD     = 1024
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                runFlag,
    input  logic [SAMPLE_W-1:0] adcDatabus,
    input  logic                fifoFull,
`ifdef TEST_PATTERN_EN
    input  logic                testMode,
`endif
    output logic [WORD_W-1:0]   adcData,
    output logic                dataValid,
    output logic                clipIndicator,
    output logic [CNT_W-1:0]    clipCount,
    output logic                overflowFlag,
    output logic [CNT_W-1:0]    overflowCount
);

    localparam int DCNT_W = (DISCARD_COUNT > 1) ? $clog2(DISCARD_COUNT) : 1;
    localparam int HOLD_W = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DISCARD_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(CLIP_HOLD - 1);

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [SAMPLE_W-1:0] stage1_q;
    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                clip_ind_q, clip_ind_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic                start_s;
    logic                clip_hit_s;
    logic                ovf_hit_s;
    logic [SAMPLE_W-1:0] src_s;

    assign start_s    = (state_q == IDLE) && runFlag;
    assign clip_hit_s = valid_q && is_clip(word_q[SAMPLE_W-1:0]);
    assign ovf_hit_s  = valid_q && fifoFull;

`ifdef TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] ramp_q;
    logic [SAMPLE_W-1:0] ramp_cur_s;

    // The ramp presents 0 on the start edge itself so the first valid word carries it
    assign ramp_cur_s = start_s ? {SAMPLE_W{1'b0}} : ramp_q;
    assign src_s      = testMode ? ramp_cur_s : adcDatabus;

    // Free-running ramp, restarted on every capture start
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            ramp_q <= {SAMPLE_W{1'b0}};
        end else begin
            ramp_q <= ramp_cur_s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign src_s = adcDatabus;
`endif

    // Capture FSM next state plus discard counter and sequence number
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        seq_d   = seq_q;
        case (state_q)
            IDLE: begin
                if (runFlag) begin
                    state_d = (DISCARD_COUNT == 0) ? RUN : DISCARD;
                end else begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (!runFlag) begin
                    state_d = IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = DISCARD;
                end
            end
            RUN: begin
                if (!runFlag) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_s) begin
            dcnt_d = {DCNT_W{1'b0}};
            seq_d  = {SEQ_W{1'b0}};
        end else if (state_q == DISCARD) begin
            dcnt_d = dcnt_q + {{(DCNT_W-1){1'b0}}, 1'b1};
        end else if (state_q == RUN) begin
            seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
        end else begin
            dcnt_d = dcnt_q;
        end
    end

    // Clip stretch and sticky overflow; a fresh clip reload beats hold expiry
    always_comb begin
        hold_d     = hold_q;
        clip_ind_d = clip_ind_q;
        ovf_flag_d = ovf_flag_q;
        if (clip_hit_s) begin
            hold_d     = HOLD_RELOAD;
            clip_ind_d = 1'b1;
        end else if (clip_ind_q && (hold_q == {HOLD_W{1'b0}})) begin
            clip_ind_d = 1'b0;
        end else if (clip_ind_q) begin
            hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            hold_d = hold_q;
        end

        if (ovf_hit_s) begin
            ovf_flag_d = 1'b1;
        end else if (start_s) begin
            ovf_flag_d = 1'b0;
        end else begin
            ovf_flag_d = ovf_flag_q;
        end
    end

    // Control state, two-stage datapath and monitor registers
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            dcnt_q     <= {DCNT_W{1'b0}};
            seq_q      <= {SEQ_W{1'b0}};
            stage1_q   <= {SAMPLE_W{1'b0}};
            word_q     <= {WORD_W{1'b0}};
            valid_q    <= 1'b0;
            hold_q     <= {HOLD_W{1'b0}};
            clip_ind_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            seq_q      <= seq_d;
            stage1_q   <= src_s;
            word_q     <= {seq_q, stage1_q};
            valid_q    <= (state_q == RUN);
            hold_q     <= hold_d;
            clip_ind_q <= clip_ind_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_clip_cnt (
        .clock   (clock),
        .nReset  (nReset),
        .inc_i   (clip_hit_s),
        .count_o (clipCount)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clock   (clock),
        .nReset  (nReset),
        .inc_i   (ovf_hit_s),
        .count_o (overflowCount)
    );

    assign adcData       = word_q;
    assign dataValid     = valid_q;
    assign clipIndicator = clip_ind_q;
    assign overflowFlag  = ovf_flag_q;

endmodule
